// File: rtl/mult_datapath.sv
// mult_datapath: shift-add multiplier datapath.
// Holds the multiplicand M and the combined accumulator/multiplier register P,
// and executes the load / add / shift commands issued by the control FSM.
// Optional feature: define MULT_DP_PROTO_CHECK_EN to build the sticky protocol
// error flag `err`; otherwise `err` is tied low and no check logic exists.
module mult_datapath #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic                 initial_wr,
    input  logic                 sh_right,
    input  logic                 wr,
    output logic                 data_in,
    output logic [2*WIDTH-1:0]   product,
    output logic                 product_valid,
    output logic                 err
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0]   m;
    logic [2*WIDTH-1:0] p;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     sum;

    // Upper half plus multiplicand; the carry is kept as the new MSB of P.
    assign sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, m};

    assign data_in = p[0];
    assign product = p;

    // Command execution: reset > load > shift (with optional add) > hold.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            m             <= '0;
            p             <= '0;
            cnt           <= '0;
            product_valid <= 1'b0;
        end else if (initial_wr) begin
            m             <= a_in;
            p             <= {{WIDTH{1'b0}}, b_in};
            cnt           <= '0;
            product_valid <= 1'b0;
        end else if (sh_right) begin
            if (wr) begin
                p <= {sum, p[WIDTH-1:1]};
            end else begin
                p <= {1'b0, p[2*WIDTH-1:1]};
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) begin
                product_valid <= 1'b1;
            end
        end
    end

`ifdef MULT_DP_PROTO_CHECK_EN
    logic overrun;
    logic early_load;

    assign overrun    = sh_right && product_valid;
    assign early_load = initial_wr && (cnt != '0) && !product_valid;

    // Sticky protocol error: cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (overrun || early_load) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// tb_mult_datapath: self-checking bench for mult_datapath.
// Emulates the controller (load, then WIDTH shift cycles with wr = data_in)
// and compares against plain arithmetic products and multiplier bit order.
module tb_mult_datapath;

    localparam int W = 64;

`ifdef MULT_DP_PROTO_CHECK_EN
    localparam logic PROTO = 1'b1;
`else
    localparam logic PROTO = 1'b0;
`endif

    logic           clk;
    logic           reset;
    logic [W-1:0]   a_in;
    logic [W-1:0]   b_in;
    logic           initial_wr;
    logic           sh_right;
    logic           wr;
    logic           data_in;
    logic [2*W-1:0] product;
    logic           product_valid;
    logic           err;

    int checks = 0;
    int errors = 0;

    mult_datapath #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .a_in          (a_in),
        .b_in          (b_in),
        .initial_wr    (initial_wr),
        .sh_right      (sh_right),
        .wr            (wr),
        .data_in       (data_in),
        .product       (product),
        .product_valid (product_valid),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2*W-1:0] obs,
                         input logic [2*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full controller-style run; checks bit order, valid timing and product.
    task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                            input string tag);
        logic [2*W-1:0] expected;
        expected   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        a_in       = a;
        b_in       = b;
        initial_wr = 1'b1;
        sh_right   = 1'b0;
        wr         = 1'b0;
        tick();
        initial_wr = 1'b0;
        a_in       = '0;
        b_in       = '0;
        for (int k = 0; k < W; k++) begin
            check({tag, "_data_in"}, {127'b0, data_in}, {127'b0, b[k]});
            check({tag, "_valid_low"}, {127'b0, product_valid}, '0);
            sh_right = 1'b1;
            wr       = data_in;
            tick();
        end
        sh_right = 1'b0;
        wr       = 1'b0;
        check({tag, "_valid"}, {127'b0, product_valid}, {127'b0, 1'b1});
        check({tag, "_product"}, product, expected);
    endtask

    initial begin
        logic [2*W-1:0] held;
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;

        reset      = 1'b1;
        a_in       = '0;
        b_in       = '0;
        initial_wr = 1'b0;
        sh_right   = 1'b0;
        wr         = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_product", product, '0);
        check("rst_valid", {127'b0, product_valid}, '0);
        check("rst_err", {127'b0, err}, '0);
        check("rst_data_in", {127'b0, data_in}, '0);

        // Directed cases from the basic, max and zero scenarios.
        run_mult(64'd3, 64'd5, "basic");
        run_mult({W{1'b1}}, {W{1'b1}}, "max");
        run_mult(64'h1234, 64'd0, "zero_b");
        run_mult(64'd0, 64'hFFFF, "zero_a");

        // Idle hold: product and valid stay; wr alone has no effect.
        held = product;
        wr   = 1'b1;
        tick();
        tick();
        wr = 1'b0;
        check("idle_product", product, held);
        check("idle_valid", {127'b0, product_valid}, {127'b0, 1'b1});

        // Reset in cycle 30 of an operation.
        a_in       = 64'hDEAD_BEEF;
        b_in       = 64'hCAFE_F00D;
        initial_wr = 1'b1;
        tick();
        initial_wr = 1'b0;
        for (int k = 1; k < 30; k++) begin
            sh_right = 1'b1;
            wr       = data_in;
            tick();
        end
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        sh_right = 1'b0;
        wr       = 1'b0;
        check("midrst_product", product, '0);
        check("midrst_valid", {127'b0, product_valid}, '0);
        check("midrst_data_in", {127'b0, data_in}, '0);
        run_mult(64'd7, 64'd9, "rerun");

        // Back-to-back: second load in the cycle after completion.
        run_mult(64'd2, 64'd3, "b2b_first");
        run_mult(64'd10, 64'd10, "b2b_second");

        // Randomized operands.
        for (int i = 0; i < 6; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            run_mult(ra, rb, "random");
        end
        check("no_false_err", {127'b0, err}, '0);

        // Overrun: one extra shift after completion.
        sh_right = 1'b1;
        wr       = data_in;
        tick();
        sh_right = 1'b0;
        wr       = 1'b0;
        check("overrun_err", {127'b0, err}, {127'b0, PROTO});
        tick();
        tick();
        check("overrun_err_held", {127'b0, err}, {127'b0, PROTO});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("err_cleared", {127'b0, err}, '0);

        // Load issued while an operation is in progress.
        a_in       = 64'd11;
        b_in       = 64'd13;
        initial_wr = 1'b1;
        tick();
        initial_wr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sh_right = 1'b1;
            wr       = data_in;
            tick();
        end
        sh_right   = 1'b0;
        wr         = 1'b0;
        initial_wr = 1'b1;
        tick();
        initial_wr = 1'b0;
        check("early_load_err", {127'b0, err}, {127'b0, PROTO});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("final_err", {127'b0, err}, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
